// File: rtl/genesis_pad_pkg.sv
// Shared constants and types for the Mega Drive / Genesis multi-pad reader.
// Button word layout, DB9 pin slice positions and FSM state encoding.
package genesis_pad_pkg;

    localparam int BTN_W      = 12;
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_A      = 4;
    localparam int BTN_B      = 5;
    localparam int BTN_C      = 6;
    localparam int BTN_X      = 7;
    localparam int BTN_Y      = 8;
    localparam int BTN_Z      = 9;
    localparam int BTN_START  = 10;
    localparam int BTN_MODE   = 11;

    // Per-pad pin slice is {pin9,pin6,pin4,pin3,pin2,pin1}
    localparam int PIN_W = 6;
    localparam int PIN1  = 0;
    localparam int PIN2  = 1;
    localparam int PIN3  = 2;
    localparam int PIN4  = 3;
    localparam int PIN6  = 4;
    localparam int PIN9  = 5;

    localparam int NUM_PHASES = 8;
    localparam int PHASE_W    = $clog2(NUM_PHASES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PHASE    = 2'd1,
        ST_PUBLISH  = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/genesis_multipad_reader_if.sv
// Bus between the pad reader and its host: start request, raw DB9 pins and
// the published per-pad button state.
interface genesis_multipad_reader_if #(
    parameter int NUM_PADS = 2
) ();

    logic                                               start;
    logic [genesis_pad_pkg::PIN_W*NUM_PADS-1:0]         pad_pins;
    logic [NUM_PADS-1:0]                                select;
    logic                                               busy;
    logic                                               done;
    logic [genesis_pad_pkg::BTN_W*NUM_PADS-1:0]         buttons;
    logic [NUM_PADS-1:0]                                pad_present;
    logic [NUM_PADS-1:0]                                six_button;

    modport master (
        output start, pad_pins,
        input  select, busy, done, buttons, pad_present, six_button
    );

    modport slave (
        input  start, pad_pins,
        output select, busy, done, buttons, pad_present, six_button
    );

endinterface

// File: rtl/genesis_pad_decoder.sv
// Per-pad pin synchroniser, phase sample capture and button decode.
// Outputs only change on the publish strobe, so a reset or abort discards partial samples.
module genesis_pad_decoder
    import genesis_pad_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [PIN_W-1:0]   pins,
    input  logic               sample,
    input  logic [PHASE_W-1:0] phase,
    input  logic               publish,
    output logic [BTN_W-1:0]   buttons,
    output logic               present,
    output logic               six_button
);

    logic [PIN_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [PIN_W-1:0] ph0_q, ph0_d, ph1_q, ph1_d, ph5_q, ph5_d, ph6_q, ph6_d;
    logic [BTN_W-1:0] buttons_q, buttons_d;
    logic             present_q, present_d, six_q, six_d;
    logic [BTN_W-1:0] btn_c;
    logic             pres_c, six_c;

    // Captured phase samples are stored inverted: 1 = pin pulled low = asserted
    always_comb begin
        sync1_d = pins;
        sync2_d = sync1_q;
        ph0_d   = ph0_q;
        ph1_d   = ph1_q;
        ph5_d   = ph5_q;
        ph6_d   = ph6_q;
        if (sample) begin
            case (phase)
                PHASE_W'(0): ph0_d = ~sync2_q;
                PHASE_W'(1): ph1_d = ~sync2_q;
                PHASE_W'(5): ph5_d = ~sync2_q;
                PHASE_W'(6): ph6_d = ~sync2_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        pres_c = ph1_q[PIN3] & ph1_q[PIN4];
        six_c  = pres_c & ph5_q[PIN1] & ph5_q[PIN2] & ph5_q[PIN3] & ph5_q[PIN4];
        btn_c             = '0;
        btn_c[BTN_UP]     = ph0_q[PIN1];
        btn_c[BTN_DOWN]   = ph0_q[PIN2];
        btn_c[BTN_LEFT]   = ph0_q[PIN3];
        btn_c[BTN_RIGHT]  = ph0_q[PIN4];
        btn_c[BTN_B]      = ph0_q[PIN6];
        btn_c[BTN_C]      = ph0_q[PIN9];
        btn_c[BTN_A]      = ph1_q[PIN6];
        btn_c[BTN_START]  = ph1_q[PIN9];
        // Extended buttons only mean something on a confirmed 6-button pad
        btn_c[BTN_Z]      = six_c & ph6_q[PIN1];
        btn_c[BTN_Y]      = six_c & ph6_q[PIN2];
        btn_c[BTN_X]      = six_c & ph6_q[PIN3];
        btn_c[BTN_MODE]   = six_c & ph6_q[PIN4];
        if (!pres_c) btn_c = '0;

        buttons_d = buttons_q;
        present_d = present_q;
        six_d     = six_q;
        if (publish) begin
            buttons_d = btn_c;
            present_d = pres_c;
            six_d     = six_c;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            ph0_q     <= '0;
            ph1_q     <= '0;
            ph5_q     <= '0;
            ph6_q     <= '0;
            buttons_q <= '0;
            present_q <= 1'b0;
            six_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            ph0_q     <= ph0_d;
            ph1_q     <= ph1_d;
            ph5_q     <= ph5_d;
            ph6_q     <= ph6_d;
            buttons_q <= buttons_d;
            present_q <= present_d;
            six_q     <= six_d;
        end
    end

    assign buttons    = buttons_q;
    assign present    = present_q;
    assign six_button = six_q;

endmodule

// File: rtl/genesis_multipad_reader.sv
// Genesis multi-pad reader: shared select-sequence FSM driving NUM_PADS ports in
// lockstep, with one decoder per port publishing buttons on a done pulse.
module genesis_multipad_reader
    import genesis_pad_pkg::*;
#(
    parameter int NUM_PADS        = 2,
    parameter int PHASE_CYCLES    = 500,
    parameter int COOLDOWN_CYCLES = 100000,
    parameter int AUTO_POLL       = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    genesis_multipad_reader_if.slave      bus
);

    localparam int PH_W = cnt_w(PHASE_CYCLES);
    localparam int CD_W = cnt_w(COOLDOWN_CYCLES);
    localparam logic [PH_W-1:0]    PH_LAST    = PH_W'(PHASE_CYCLES - 1);
    localparam logic [CD_W-1:0]    CD_LAST    = CD_W'(COOLDOWN_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASES - 1);

    state_e               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
    logic [CD_W-1:0]      cd_cnt_q, cd_cnt_d;
    logic [NUM_PADS-1:0]  select_q, select_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ph_last, sample_stb, publish_stb;

    assign ph_last     = (ph_cnt_q == PH_LAST);
    assign sample_stb  = (state_q == ST_PHASE) && ph_last;
    assign publish_stb = sample_stb && (phase_q == PHASE_LAST);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        ph_cnt_d = ph_cnt_q;
        cd_cnt_d = cd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start || (AUTO_POLL != 0)) begin
                    state_d = ST_PHASE;
                    phase_d = '0;
                end
            end
            ST_PHASE: begin
                if (ph_last) begin
                    ph_cnt_d = '0;
                    if (phase_q == PHASE_LAST) begin
                        state_d = ST_PUBLISH;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + PHASE_W'(1);
                    end
                end else begin
                    ph_cnt_d = ph_cnt_q + PH_W'(1);
                end
            end
            ST_PUBLISH: state_d = ST_COOLDOWN;
            ST_COOLDOWN: begin
                if (cd_cnt_q == CD_LAST) begin
                    state_d  = ST_IDLE;
                    cd_cnt_d = '0;
                end else begin
                    cd_cnt_d = cd_cnt_q + CD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it
        select_d = {NUM_PADS{~((state_d == ST_PHASE) && phase_d[0])}};
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_PUBLISH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            ph_cnt_q <= '0;
            cd_cnt_q <= '0;
            select_q <= '1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            ph_cnt_q <= ph_cnt_d;
            cd_cnt_q <= cd_cnt_d;
            select_q <= select_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    logic [NUM_PADS-1:0][BTN_W-1:0] btn_w;
    logic [NUM_PADS-1:0]            pres_w, six_w;

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        genesis_pad_decoder u_dec (
            .clock      (clock),
            .reset      (reset),
            .pins       (bus.pad_pins[p*PIN_W +: PIN_W]),
            .sample     (sample_stb),
            .phase      (phase_q),
            .publish    (publish_stb),
            .buttons    (btn_w[p]),
            .present    (pres_w[p]),
            .six_button (six_w[p])
        );
    end

    assign bus.select      = select_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.buttons     = btn_w;
    assign bus.pad_present = pres_w;
    assign bus.six_button  = six_w;

endmodule

// File: tb/tb_genesis_multipad_reader.sv
// Scoreboard bench: behavioural DB9 pad models (absent / 3-button / 6-button) feed
// a manual-start reader and an auto-poll reader; monitors pop expectations on done.
`timescale 1ns/1ps
module tb_genesis_multipad_reader;
    import genesis_pad_pkg::*;

    localparam int NP = 2;
    localparam int PC = 4;
    localparam int CC = 16;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    genesis_multipad_reader_if #(.NUM_PADS(NP)) ifa ();
    genesis_multipad_reader_if #(.NUM_PADS(NP)) ifb ();

    genesis_multipad_reader #(.NUM_PADS(NP), .PHASE_CYCLES(PC), .COOLDOWN_CYCLES(CC), .AUTO_POLL(0))
        dut_a (.clock(clk), .reset(rst_a), .bus(ifa.slave));
    genesis_multipad_reader #(.NUM_PADS(NP), .PHASE_CYCLES(PC), .COOLDOWN_CYCLES(CC), .AUTO_POLL(1))
        dut_b (.clock(clk), .reset(rst_b), .bus(ifb.slave));

    // Pad models: type 0 = unplugged, 3 = 3-button, 6 = 6-button; index [dut][pad]
    int          ptype [2][NP];
    logic [11:0] held  [2][NP];
    int          kph   [2][NP];
    int          hicnt [2][NP];
    logic        selp  [2][NP];
    logic        s_m;

    // Real pad behaviour: combinational on select, with the 6-button pad counting
    // select transitions and forgetting after select idles high for a while.
    function automatic logic [5:0] pad_drive(input int t, input logic [11:0] b, input int k, input logic s);
        logic [5:0] act;
        if (t == 0) return 6'h3F;
        if (s) begin
            if (t == 6 && k == 6)      act = {b[BTN_C], b[BTN_B], b[BTN_MODE], b[BTN_X], b[BTN_Y], b[BTN_Z]};
            else if (t == 3 && k == 6) act = {b[BTN_C], b[BTN_B], 4'hF};
            else                       act = {b[BTN_C], b[BTN_B], b[BTN_RIGHT], b[BTN_LEFT], b[BTN_DOWN], b[BTN_UP]};
        end else begin
            if (t == 6 && k == 5)      act = {b[BTN_START], b[BTN_A], 4'hF};
            else if (t == 6 && k == 7) act = {b[BTN_START], b[BTN_A], 4'h0};
            else                       act = {b[BTN_START], b[BTN_A], 2'b11, b[BTN_DOWN], b[BTN_UP]};
        end
        return ~act;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                s_m = (d == 0) ? ifa.select[p] : ifb.select[p];
                if (s_m != selp[d][p]) begin
                    kph[d][p]   = kph[d][p] + 1;
                    hicnt[d][p] = 0;
                end else if (s_m) begin
                    hicnt[d][p] = hicnt[d][p] + 1;
                    if (hicnt[d][p] >= 8) kph[d][p] = 0;
                end
                selp[d][p] = s_m;
                if (d == 0) ifa.pad_pins[p*6 +: 6] = pad_drive(ptype[d][p], held[d][p], kph[d][p], s_m);
                else        ifb.pad_pins[p*6 +: 6] = pad_drive(ptype[d][p], held[d][p], kph[d][p], s_m);
            end
        end
    end

    typedef struct {
        logic [NP*12-1:0] btn;
        logic [NP-1:0]    pres;
        logic [NP-1:0]    six;
        int               cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   checks = 0;
    int   errors = 0;
    logic auto_run = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t make_exp(input int d, input int c);
        exp_t e;
        e.btn  = '0;
        e.pres = '0;
        e.six  = '0;
        e.cyc  = c;
        for (int p = 0; p < NP; p++) begin
            if (ptype[d][p] == 3)      e.btn[p*12 +: 12] = held[d][p] & 12'h47F;
            else if (ptype[d][p] == 6) e.btn[p*12 +: 12] = held[d][p];
            e.pres[p] = (ptype[d][p] != 0);
            e.six[p]  = (ptype[d][p] == 6);
        end
        return e;
    endfunction

    function automatic logic [11:0] rand_btn();
        logic [11:0] r;
        r = 12'($urandom);
        if (r[BTN_UP] && r[BTN_DOWN])    r[BTN_DOWN]  = 1'b0;
        if (r[BTN_LEFT] && r[BTN_RIGHT]) r[BTN_RIGHT] = 1'b0;
        return r;
    endfunction

    function automatic int rand_type();
        int r;
        r = int'($urandom_range(0, 2));
        return (r == 0) ? 0 : (r == 1) ? 3 : 6;
    endfunction

    always @(negedge clk) begin
        if (!rst_a && ifa.done) begin
            if (q_a.size() == 0) chk("a_unexpected_done", 64'(1), 64'(0));
            else begin
                ea = q_a.pop_front();
                chk("a_buttons", 64'(ifa.buttons), 64'(ea.btn));
                chk("a_present", 64'(ifa.pad_present), 64'(ea.pres));
                chk("a_six", 64'(ifa.six_button), 64'(ea.six));
                chk("a_done_cycle", 64'(cyc), 64'(ea.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_b && auto_run && ifb.done) begin
            if (q_b.size() == 0) chk("b_unexpected_done", 64'(1), 64'(0));
            else begin
                eb = q_b.pop_front();
                chk("b_buttons", 64'(ifb.buttons), 64'(eb.btn));
                chk("b_present", 64'(ifb.pad_present), 64'(eb.pres));
                chk("b_six", 64'(ifb.six_button), 64'(eb.six));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while ((q_a.size() != 0 || ifa.busy) && n < 300) begin
            tick(1);
            n++;
        end
        chk("a_idle_timeout", 64'(n < 300), 64'(1));
    endtask

    task automatic seq_a();
        // Abort mid-PHASE(3): no done, outputs back to reset values
        ptype[0][0] = 6; held[0][0] = 12'h211;
        ptype[0][1] = 0; held[0][1] = 12'hFFF;
        tick(2);
        ifa.start = 1'b1;
        tick(1);
        ifa.start = 1'b0;
        tick(13);
        rst_a = 1'b1;
        tick(1);
        chk("abort_select", 64'(ifa.select), 64'(2'b11));
        chk("abort_busy", 64'(ifa.busy), 64'(0));
        chk("abort_buttons", 64'(ifa.buttons), 64'(0));
        chk("abort_present", 64'(ifa.pad_present), 64'(0));
        tick(2);
        rst_a = 1'b0;
        tick(12);

        // Full sequence with select waveform, ignored starts and restart timing
        ifa.start = 1'b1;
        q_a.push_back(make_exp(0, cyc + 33));
        tick(1);
        ifa.start = 1'b0;
        for (int c = 1; c <= 51; c++) begin
            if (c <= 34)
                chk("select_wave", 64'(ifa.select),
                    64'((c >= 33 || ((c - 1) / PC) % 2 == 0) ? 2'b11 : 2'b00));
            if (c == 10 || c == 40) begin
                chk("busy_at_ignored_start", 64'(ifa.busy), 64'(1));
                ifa.start = 1'b1;
            end
            if (c == 11 || c == 41 || c == 51) ifa.start = 1'b0;
            if (c == 45) begin
                held[0][0]  = 12'h0A8;
                ptype[0][1] = 3;
                held[0][1]  = 12'h440;
            end
            if (c == 49) chk("busy_last_cooldown", 64'(ifa.busy), 64'(1));
            if (c == 50) begin
                chk("busy_after_cooldown", 64'(ifa.busy), 64'(0));
                ifa.start = 1'b1;
                q_a.push_back(make_exp(0, cyc + 33));
            end
            tick(1);
        end
        wait_idle_a();

        // Randomised pad populations and button holds
        for (int i = 0; i < 10; i++) begin
            for (int p = 0; p < NP; p++) begin
                ptype[0][p] = rand_type();
                held[0][p]  = rand_btn();
            end
            tick(1 + int'($urandom_range(0, 3)));
            ifa.start = 1'b1;
            q_a.push_back(make_exp(0, cyc + 33));
            tick(1);
            ifa.start = 1'b0;
            wait_idle_a();
        end
    endtask

    task automatic auto_thread();
        int n;
        int last;
        last = 0;
        ptype[1][0] = 6; held[1][0] = rand_btn();
        ptype[1][1] = 3; held[1][1] = rand_btn();
        q_b.push_back(make_exp(1, -1));
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            @(negedge clk);
            while (!ifb.done && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("b_done_seen", 64'(ifb.done), 64'(1));
            if (i > 0) chk("b_period", 64'(cyc - last), 64'(50));
            last = cyc;
            if (i < 4) begin
                held[1][0] = rand_btn();
                q_b.push_back(make_exp(1, -1));
            end
        end
        #1 auto_run = 1'b0;
    endtask

    initial begin : main
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                ptype[d][p] = 0;
                held[d][p]  = '0;
                kph[d][p]   = 0;
                hicnt[d][p] = 0;
                selp[d][p]  = 1'b1;
            end
        end
        ifa.start    = 1'b0;
        ifb.start    = 1'b0;
        ifa.pad_pins = '1;
        ifb.pad_pins = '1;
        tick(12);
        chk("reset_select", 64'(ifa.select), 64'(2'b11));
        chk("reset_busy", 64'(ifa.busy), 64'(0));
        chk("reset_done", 64'(ifa.done), 64'(0));
        chk("reset_buttons", 64'(ifa.buttons), 64'(0));
        chk("reset_present", 64'(ifa.pad_present), 64'(0));
        chk("reset_six", 64'(ifa.six_button), 64'(0));
        rst_a = 1'b0;
        fork
            seq_a();
            auto_thread();
        join
        tick(2);
        chk("queues_drained", 64'(q_a.size() + q_b.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
